// File: rtl/lif_neuron_array.sv
// Array of independent leaky integrate-and-fire neurons with fixed-point potentials.
// One registered stage: a step edge leaks, integrates, fires and updates refractory state.
module lif_neuron_array #(
    parameter int NUM_NEURONS = 4,
    parameter int DATA_W      = 8,
    parameter int FRAC_W      = 4,
    parameter int THRESHOLD   = 64,
    parameter int LEAK_FACTOR = 12,
    parameter int WEIGHT      = 24,
    parameter int RESET_MODE  = 0,
    parameter int REFRAC      = 2,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          step,
    input  logic [NUM_NEURONS-1:0]        in_spike,
    output logic [NUM_NEURONS-1:0]        spike,
    output logic [NUM_NEURONS*DATA_W-1:0] potential,
    output logic [NUM_NEURONS-1:0]        refractory,
    output logic [CNT_W-1:0]              spike_count
);

    localparam int PROD_W = DATA_W + FRAC_W + 1;
    localparam int SUM_W  = DATA_W + 1;
    localparam int RC_W   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int POP_W  = $clog2(NUM_NEURONS + 1);
    localparam int WIDE_W = CNT_W + POP_W;

    localparam logic [DATA_W-1:0] THR     = DATA_W'(THRESHOLD);
    localparam logic [PROD_W-1:0] LEAK    = PROD_W'(LEAK_FACTOR);
    localparam logic [SUM_W-1:0]  WGT     = SUM_W'(WEIGHT);
    localparam logic [RC_W-1:0]   RC_INIT = RC_W'(REFRAC);

    // Floor of p * LEAK_FACTOR in the potential's Q format.
    function automatic logic [SUM_W-1:0] leak_fn(input logic [DATA_W-1:0] p);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(p) * LEAK;
        return SUM_W'(prod >> FRAC_W);
    endfunction

    function automatic logic [DATA_W-1:0] sat_fn(input logic [SUM_W-1:0] s);
        return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_fn(input logic [CNT_W-1:0] c,
                                                   input logic [POP_W-1:0] n);
        logic [WIDE_W-1:0] wide;
        wide = WIDE_W'(c) + WIDE_W'(n);
        return (wide[WIDE_W-1:CNT_W] != '0) ? {CNT_W{1'b1}} : wide[CNT_W-1:0];
    endfunction

    logic [DATA_W-1:0]      pot_p1   [NUM_NEURONS];
    logic [RC_W-1:0]        rc_p1    [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spike_p1;
    logic [NUM_NEURONS-1:0] ref_p1;
    logic [CNT_W-1:0]       cnt_p1;

    logic [DATA_W-1:0]      pot_p0   [NUM_NEURONS];
    logic [RC_W-1:0]        rc_p0    [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] fire_p0;
    logic [POP_W-1:0]       pop_p0;
    logic [SUM_W-1:0]       sum_p0;
    logic [DATA_W-1:0]      sat_p0;

    // Stage 0: per-neuron leak / integrate / fire decision
    always_comb begin
        fire_p0 = '0;
        pop_p0  = '0;
        sum_p0  = '0;
        sat_p0  = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            pot_p0[i] = pot_p1[i];
            rc_p0[i]  = rc_p1[i];
            if (step) begin
                if (rc_p1[i] != '0) begin
                    rc_p0[i] = rc_p1[i] - 1'b1;
                end else begin
                    sum_p0 = leak_fn(pot_p1[i]) + (in_spike[i] ? WGT : '0);
                    sat_p0 = sat_fn(sum_p0);
                    if (sat_p0 >= THR) begin
                        fire_p0[i] = 1'b1;
                        pot_p0[i]  = (RESET_MODE != 0) ? (sat_p0 - THR) : '0;
                        rc_p0[i]   = RC_INIT;
                    end else begin
                        pot_p0[i] = sat_p0;
                    end
                end
            end
            pop_p0 = pop_p0 + POP_W'(fire_p0[i]);
        end
    end

    // Stage 1: registered neuron state and outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_p1[i] <= '0;
                rc_p1[i]  <= '0;
            end
            spike_p1 <= '0;
            ref_p1   <= '0;
            cnt_p1   <= '0;
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_p1[i] <= pot_p0[i];
                rc_p1[i]  <= rc_p0[i];
                ref_p1[i] <= (rc_p0[i] != '0);
            end
            spike_p1 <= fire_p0;
            if (step) begin
                cnt_p1 <= cnt_sat_fn(cnt_p1, pop_p0);
            end
        end
    end

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_pot
        assign potential[g*DATA_W +: DATA_W] = pot_p1[g];
    end

    assign spike       = spike_p1;
    assign refractory  = ref_p1;
    assign spike_count = cnt_p1;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: four parameter variants on a shared stimulus bus,
// a reference model feeding a scoreboard, plus a hand-computed vector table.
module tb_lif_neuron_array;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic [3:0] in_spike = '0;

    logic [3:0][31:0] pot_w;
    logic [3:0][3:0]  sp_w;
    logic [3:0][3:0]  rf_w;
    logic [3:0][15:0] cnt_w;
    logic [1:0]       cnt_small;

    always #5 clk = ~clk;

    lif_neuron_array u_def (
        .clk(clk), .rst_n(rst_n), .step(step), .in_spike(in_spike),
        .spike(sp_w[0]), .potential(pot_w[0]), .refractory(rf_w[0]), .spike_count(cnt_w[0]));

    lif_neuron_array #(.RESET_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .step(step), .in_spike(in_spike),
        .spike(sp_w[1]), .potential(pot_w[1]), .refractory(rf_w[1]), .spike_count(cnt_w[1]));

    lif_neuron_array #(.LEAK_FACTOR(16), .THRESHOLD(255), .WEIGHT(240)) u_sat (
        .clk(clk), .rst_n(rst_n), .step(step), .in_spike(in_spike),
        .spike(sp_w[2]), .potential(pot_w[2]), .refractory(rf_w[2]), .spike_count(cnt_w[2]));

    lif_neuron_array #(.CNT_W(2)) u_cnt (
        .clk(clk), .rst_n(rst_n), .step(step), .in_spike(in_spike),
        .spike(sp_w[3]), .potential(pot_w[3]), .refractory(rf_w[3]), .spike_count(cnt_small));

    assign cnt_w[3] = {14'b0, cnt_small};

    int checks = 0;
    int failures = 0;

    int P_THR  [4] = '{64, 64, 255, 64};
    int P_LK   [4] = '{12, 12, 16, 12};
    int P_W    [4] = '{24, 24, 240, 24};
    int P_MODE [4] = '{0, 1, 0, 0};
    int P_CMAX [4] = '{65535, 65535, 65535, 3};

    int mp  [4][4];
    int mrc [4][4];
    int mcnt[4];

    typedef struct packed {
        logic [3:0][31:0] pot;
        logic [3:0][3:0]  sp;
        logic [3:0][3:0]  rf;
        logic [3:0][15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    typedef struct packed {
        logic       st;
        logic       in0;
        logic [7:0] p_def;
        logic       sp_def;
        logic       rf_def;
        logic [7:0] p_m1;
        logic       sp_m1;
        logic       rf_m1;
        logic [7:0] p_sat;
        logic       sp_sat;
        logic       rf_sat;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: advance every variant by one clock edge and queue the expectation.
    task automatic model_push(input logic r, input logic s, input logic [3:0] in);
        exp_t e;
        int sum;
        int pop;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            pop = 0;
            for (int n = 0; n < 4; n++) begin
                if (!r) begin
                    mp[k][n]  = 0;
                    mrc[k][n] = 0;
                end else if (s) begin
                    if (mrc[k][n] > 0) begin
                        mrc[k][n] = mrc[k][n] - 1;
                    end else begin
                        sum = (mp[k][n] * P_LK[k]) / 16 + (in[n] ? P_W[k] : 0);
                        if (sum > 255) sum = 255;
                        if (sum >= P_THR[k]) begin
                            e.sp[k][n] = 1'b1;
                            pop++;
                            mp[k][n]  = (P_MODE[k] != 0) ? sum - P_THR[k] : 0;
                            mrc[k][n] = 2;
                        end else begin
                            mp[k][n] = sum;
                        end
                    end
                end
                e.pot[k][n*8 +: 8] = mp[k][n][7:0];
                e.rf[k][n]         = (mrc[k][n] != 0);
            end
            if (!r) mcnt[k] = 0;
            else if (s) mcnt[k] = (mcnt[k] + pop > P_CMAX[k]) ? P_CMAX[k] : mcnt[k] + pop;
            e.cnt[k] = mcnt[k][15:0];
        end
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic s, input logic [3:0] in);
        exp_t e;
        rst_n    = r;
        step     = s;
        in_spike = in;
        model_push(r, s, in);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("sb_pot[%0d]", k), pot_w[k], e.pot[k]);
                chk($sformatf("sb_spike[%0d]", k), {28'b0, sp_w[k]}, {28'b0, e.sp[k]});
                chk($sformatf("sb_ref[%0d]", k), {28'b0, rf_w[k]}, {28'b0, e.rf[k]});
                chk($sformatf("sb_cnt[%0d]", k), {16'b0, cnt_w[k]}, {16'b0, e.cnt[k]});
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            mcnt[k] = 0;
            for (int n = 0; n < 4; n++) begin
                mp[k][n]  = 0;
                mrc[k][n] = 0;
            end
        end

        //           st in  def        m1         sat
        tbl[0]  = '{1, 1, 24, 0, 0, 24, 0, 0, 240, 0, 0};
        tbl[1]  = '{1, 1, 42, 0, 0, 42, 0, 0,   0, 1, 1};
        tbl[2]  = '{1, 1, 55, 0, 0, 55, 0, 0,   0, 0, 1};
        tbl[3]  = '{1, 1,  0, 1, 1,  1, 1, 1,   0, 0, 0};
        tbl[4]  = '{0, 0,  0, 0, 1,  1, 0, 1,   0, 0, 0};
        tbl[5]  = '{1, 1,  0, 0, 1,  1, 0, 1, 240, 0, 0};
        tbl[6]  = '{1, 1,  0, 0, 0,  1, 0, 0,   0, 1, 1};
        tbl[7]  = '{1, 1, 24, 0, 0, 24, 0, 0,   0, 0, 1};
        for (int i = 8; i < 13; i++) tbl[i] = '{0, 0, 24, 0, 0, 24, 0, 0, 0, 0, 1};
        tbl[13] = '{1, 0, 18, 0, 0, 18, 0, 0,   0, 0, 0};
        tbl[14] = '{1, 0, 13, 0, 0, 13, 0, 0,   0, 0, 0};
        tbl[15] = '{1, 0,  9, 0, 0,  9, 0, 0,   0, 0, 0};
        tbl[16] = '{1, 0,  6, 0, 0,  6, 0, 0,   0, 0, 0};

        drive(1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 4'hF);
        chk("reset_pot_def", pot_w[0], 32'd0);
        chk("reset_cnt_def", {16'b0, cnt_w[0]}, 32'd0);
        chk("reset_ref_def", {28'b0, rf_w[0]}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            drive(1'b1, tbl[i].st, {3'b0, tbl[i].in0});
            chk($sformatf("tbl%0d_p_def", i), {24'b0, pot_w[0][7:0]}, {24'b0, tbl[i].p_def});
            chk($sformatf("tbl%0d_sp_def", i), {31'b0, sp_w[0][0]}, {31'b0, tbl[i].sp_def});
            chk($sformatf("tbl%0d_rf_def", i), {31'b0, rf_w[0][0]}, {31'b0, tbl[i].rf_def});
            chk($sformatf("tbl%0d_p_m1", i), {24'b0, pot_w[1][7:0]}, {24'b0, tbl[i].p_m1});
            chk($sformatf("tbl%0d_sp_m1", i), {31'b0, sp_w[1][0]}, {31'b0, tbl[i].sp_m1});
            chk($sformatf("tbl%0d_rf_m1", i), {31'b0, rf_w[1][0]}, {31'b0, tbl[i].rf_m1});
            chk($sformatf("tbl%0d_p_sat", i), {24'b0, pot_w[2][7:0]}, {24'b0, tbl[i].p_sat});
            chk($sformatf("tbl%0d_sp_sat", i), {31'b0, sp_w[2][0]}, {31'b0, tbl[i].sp_sat});
            chk($sformatf("tbl%0d_rf_sat", i), {31'b0, rf_w[2][0]}, {31'b0, tbl[i].rf_sat});
        end
        chk("tbl_cnt_def", {16'b0, cnt_w[0]}, 32'd1);
        chk("tbl_cnt_m1", {16'b0, cnt_w[1]}, 32'd1);
        chk("tbl_cnt_sat", {16'b0, cnt_w[2]}, 32'd2);

        // All four channels fire together, then reset lands mid-refractory.
        drive(1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'hF);
        chk("all_fire_spike", {28'b0, sp_w[0]}, 32'hF);
        chk("all_fire_pot", pot_w[0], 32'd0);
        chk("all_fire_ref", {28'b0, rf_w[0]}, 32'hF);
        chk("all_fire_cnt", {16'b0, cnt_w[0]}, 32'd4);
        chk("all_fire_cnt_sat", {30'b0, cnt_small}, 32'd3);
        drive(1'b0, 1'b1, 4'hF);
        chk("midrun_rst_spike", {28'b0, sp_w[0]}, 32'd0);
        chk("midrun_rst_pot", pot_w[0], 32'd0);
        chk("midrun_rst_ref", {28'b0, rf_w[0]}, 32'd0);
        chk("midrun_rst_cnt", {16'b0, cnt_w[0]}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            drive(1'b1, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
        end
        drive(1'b0, 1'b0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
